// File: rtl/cpu_pkg.sv
// Shared definitions for the ARM-subset pipeline.
//   ADDR_W_DEF / DATA_W_DEF : default address and instruction widths
//   RESET_PC_DEF            : default program counter after reset
//   PC_STEP                 : byte increment between sequential instructions
//   NOP_INSTR               : encoding used for pipeline bubbles
//   sat_inc()               : saturating increment shared by perf counters
package cpu_pkg;

    localparam int          ADDR_W_DEF   = 32;
    localparam int          DATA_W_DEF   = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam int          PC_STEP      = 4;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;

    // Increment v (interpreted as a w-bit value, 1 <= w <= 64), sticking at
    // all-ones instead of wrapping. Callers cast to and from 64 bits.
    function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
        logic [63:0] mask;
        mask = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        if ((v & mask) == mask) begin
            return mask;
        end
        return (v + 64'd1) & mask;
    endfunction

endpackage

// File: rtl/if_pc_reg.sv
// Program counter register for the fetch stage.
//   clk, rst   : clock and synchronous active-high reset (pc -> RESET_PC)
//   load       : take load_addr (word-aligned) this edge; beats en
//   load_addr  : redirect target byte address
//   en         : advance pc by PC_STEP this edge
//   pc         : current program counter (always word aligned)
//   pc_inc     : pc + PC_STEP, modulo 2^ADDR_W
module if_pc_reg
    import cpu_pkg::*;
#(
    parameter int               ADDR_W   = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF[ADDR_W-1:0]
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic              en,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_inc
);

    logic [ADDR_W-1:0] pc_q;

    // Natural ADDR_W-bit addition gives the required wrap at the top of memory.
    assign pc_inc = pc_q + ADDR_W'(PC_STEP);
    assign pc     = pc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else if (load) begin
            pc_q <= {load_addr[ADDR_W-1:2], 2'b00};
        end else if (en) begin
            pc_q <= pc_inc;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory,
// registers the returned word into IF/ID, and counts fetches/stalls.
//   clk, rst      : clock, synchronous active-high reset
//   freeze        : hazard stall, hold PC and IF/ID
//   branch_taken  : redirect from EXE (flushes IF/ID, beats freeze/wait)
//   branch_addr   : redirect target byte address
//   imem_addr     : byte address to instruction memory (= pc)
//   imem_rdata    : instruction word for imem_addr
//   imem_ready    : imem_rdata valid this cycle
//   id_pc         : PC+4 of the instruction held in IF/ID
//   id_instr      : instruction held in IF/ID
//   id_valid      : IF/ID holds a real instruction
//   fetch_count   : instructions delivered to IF/ID (saturating)
//   stall_count   : freeze or wait-state cycles (saturating)
module if_fetch_stage
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                DATA_W   = DATA_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF[ADDR_W-1:0],
    parameter int                CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_addr,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              imem_ready,
    output logic [ADDR_W-1:0] id_pc,
    output logic [DATA_W-1:0] id_instr,
    output logic              id_valid,
    output logic [CNT_W-1:0]  fetch_count,
    output logic [CNT_W-1:0]  stall_count
);

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_inc;
    logic              advance;
    logic              stall;

    logic [ADDR_W-1:0] id_pc_p1;
    logic [DATA_W-1:0] id_instr_p1;
    logic              vld_p1;
    logic [CNT_W-1:0]  fetch_cnt_q;
    logic [CNT_W-1:0]  stall_cnt_q;

    // Redirect wins over everything; freeze wins over a memory wait.
    assign advance = !branch_taken && !freeze && imem_ready;
    assign stall   = !branch_taken && (freeze || !imem_ready);

    if_pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk       (clk),
        .rst       (rst),
        .load      (branch_taken),
        .load_addr (branch_addr),
        .en        (advance),
        .pc        (pc),
        .pc_inc    (pc_inc)
    );

    assign imem_addr = pc;

    // ---- IF -> ID pipeline boundary ----
    always_ff @(posedge clk) begin
        if (rst) begin
            id_pc_p1    <= '0;
            id_instr_p1 <= DATA_W'(NOP_INSTR);
            vld_p1      <= 1'b0;
        end else if (branch_taken) begin
            id_pc_p1    <= '0;
            id_instr_p1 <= DATA_W'(NOP_INSTR);
            vld_p1      <= 1'b0;
        end else if (freeze) begin
            id_pc_p1    <= id_pc_p1;
            id_instr_p1 <= id_instr_p1;
            vld_p1      <= vld_p1;
        end else if (!imem_ready) begin
            // ID has consumed the previous entry, so insert a bubble.
            id_instr_p1 <= DATA_W'(NOP_INSTR);
            vld_p1      <= 1'b0;
        end else begin
            id_pc_p1    <= pc_inc;
            id_instr_p1 <= imem_rdata;
            vld_p1      <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (advance) begin
                fetch_cnt_q <= CNT_W'(sat_inc(64'(fetch_cnt_q), CNT_W));
            end
            if (stall) begin
                stall_cnt_q <= CNT_W'(sat_inc(64'(stall_cnt_q), CNT_W));
            end
        end
    end

    assign id_pc       = id_pc_p1;
    assign id_instr    = id_instr_p1;
    assign id_valid    = vld_p1;
    assign fetch_count = fetch_cnt_q;
    assign stall_count = stall_cnt_q;

endmodule
